inst_dma_loader: RTL and testbench
==================================

// Module: inst_dma_loader
// PURPOSE
//   Boot-time loader that feeds the instruction memory's DMA write port.
//   Takes a byte stream (valid/ready) from the host link and packs 4 bytes, little-endian, into each instruction word.
//   Writes each word to consecutive word addresses starting at 0, and holds the CPU while loading.
//   Sits directly upstream of inst_mem: drives dma_inst_mem_waddr/wdata and inst_mem_write.
// PARAMETERS
//   INST_WIDTH       32    instruction word width (must be 32: 4 bytes per word)
//   INST_ADDR_WIDTH  32    width of dma_inst_mem_waddr (word address)
//   NUM_WORDS        128   instruction memory depth; longer loads are clamped to this
//   BYTE_TIMEOUT     1024  idle cycles allowed between bytes before the load errors out
// PORTS
//   cpu_clk             in   1                clock
//   cpu_rst_n           in   1                asynchronous, active-low reset
//   load_start          in   1                one-cycle start pulse; sampled only in IDLE/DONE/ERR
//   load_num_words      in   INST_ADDR_WIDTH  number of words to load; latched at start
//   byte_valid          in   1                host byte available
//   byte_data           in   8                host byte
//   byte_ready          out  1                loader accepts byte (transfer = valid & ready)
//   dma_inst_mem_waddr  out  INST_ADDR_WIDTH  word address to instruction memory
//   dma_inst_mem_wdata  out  INST_WIDTH       packed instruction word
//   inst_mem_write      out  1                one-cycle write strobe
//   cpu_hold            out  1                high while loading; CPU must stall/stay in reset
//   load_done           out  1                high from completion until the next start
//   load_err            out  1                high after a byte timeout until the next start
// BEHAVIOUR
//   Reset (async, cpu_rst_n=0):
//   - All outputs go to 0, FSM to IDLE, and all counters clear.
//   - Reset mid-load abandons the load; words already written stay in memory.
//   All outputs are registered.
//   FSM states: IDLE, COLLECT, WRITE, DONE, ERR.
//   IDLE/DONE/ERR, load_start=1:
//   - Latch N = min(load_num_words, NUM_WORDS).
//   - Clear word_cnt, byte_cnt, timer, load_done and load_err.
//   - If N==0, go to DONE (load_done=1 next cycle, no writes); otherwise go to COLLECT.
//   COLLECT:
//   - byte_ready=1 and cpu_hold=1.
//   - On a transfer, byte_cnt k (0..3) places byte_data into word bits [8k+7:8k], and the timer clears.
//   - A transfer with k==3 goes to WRITE. On that edge: waddr<=word_cnt, wdata<=assembled word (including this byte), inst_mem_write<=1.
//   - With no transfer, the timer increments. Reaching BYTE_TIMEOUT goes to ERR (load_err=1, cpu_hold=0).
//   WRITE (exactly 1 cycle):
//   - inst_mem_write=1, byte_ready=0, cpu_hold=1.
//   - Next edge: inst_mem_write<=0 and word_cnt increments.
//   - If word_cnt==N-1, go to DONE (load_done<=1, cpu_hold<=0); otherwise return to COLLECT with byte_cnt=0.
//   Latency: the strobe is visible in the cycle after the 4th byte handshake.
//   Throughput: at most 1 word per 5 cycles.
//   load_start while in COLLECT/WRITE is ignored.
//   byte_valid outside COLLECT is not consumed (byte_ready=0).
//   dma_inst_mem_waddr/wdata hold their last value when not writing.
//   Addresses never exceed NUM_WORDS-1. The timer saturates and never wraps.
// TESTING
//   1. start,N=2; bytes 13 00 00 00 93 00 10 00 back-to-back -> writes [0]=00000013, [1]=00100093; load_done=1; cpu_hold falls with done.
//   2. N=1; bytes with 3 idle cycles of byte_valid=0 between each -> single write [0]=DDCCBBAA for bytes AA BB CC DD; byte_ready=0 during WRITE.
//   3. N=1; send 2 bytes, then stall BYTE_TIMEOUT cycles -> load_err=1, cpu_hold=0, no inst_mem_write; a new start clears load_err.
//   4. N=0 -> load_done=1 the next cycle, no write; N=200 -> exactly 128 writes, last waddr=127.
//   5. Pulse load_start mid-load -> ignored, word_cnt unchanged; assert cpu_rst_n=0 mid-word -> all outputs 0 immediately, FSM IDLE.
//   6. Drive byte_valid=1 while in IDLE/DONE -> byte_ready stays 0, no bytes consumed.

Source files
------------

// File: rtl/inst_dma_loader_if.sv
// Host-side byte stream, load control/status and instruction-memory DMA write
// port of the boot-time instruction loader, bundled for a single port connection.
interface inst_dma_loader_if #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32
);
    logic                       load_start;
    logic [INST_ADDR_WIDTH-1:0] load_num_words;
    logic                       byte_valid;
    logic [7:0]                 byte_data;
    logic                       byte_ready;
    logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr;
    logic [INST_WIDTH-1:0]      dma_inst_mem_wdata;
    logic                       inst_mem_write;
    logic                       cpu_hold;
    logic                       load_done;
    logic                       load_err;

    // Host / boot controller side.
    modport master (
        output load_start, load_num_words, byte_valid, byte_data,
        input  byte_ready, dma_inst_mem_waddr, dma_inst_mem_wdata,
               inst_mem_write, cpu_hold, load_done, load_err
    );

    // Loader side.
    modport slave (
        input  load_start, load_num_words, byte_valid, byte_data,
        output byte_ready, dma_inst_mem_waddr, dma_inst_mem_wdata,
               inst_mem_write, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/inst_dma_loader.sv
// Boot-time loader: packs a little-endian byte stream into instruction words and
// writes them to consecutive word addresses of inst_mem while holding the CPU.
module inst_dma_loader #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int NUM_WORDS       = 128,
    parameter int BYTE_TIMEOUT    = 1024
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst_n,
    inst_dma_loader_if.slave    bus
);

    localparam int TIMER_W = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [INST_ADDR_WIDTH-1:0] NUM_WORDS_C = INST_ADDR_WIDTH'(NUM_WORDS);
    localparam logic [TIMER_W-1:0]         TIMEOUT_C   = TIMER_W'(BYTE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                     state_q,     state_d;
    logic [INST_ADDR_WIDTH-1:0] n_q,         n_d;
    logic [INST_ADDR_WIDTH-1:0] word_cnt_q,  word_cnt_d;
    logic [1:0]                 byte_cnt_q,  byte_cnt_d;
    logic [TIMER_W-1:0]         timer_q,     timer_d;
    logic [INST_WIDTH-1:0]      word_q,      word_d;
    logic [INST_ADDR_WIDTH-1:0] waddr_q,     waddr_d;
    logic [INST_WIDTH-1:0]      wdata_q,     wdata_d;
    logic                       byte_ready_q, byte_ready_d;
    logic                       write_q,     write_d;
    logic                       hold_q,      hold_d;
    logic                       done_q,      done_d;
    logic                       err_q,       err_d;

    logic                       xfer;
    logic [INST_ADDR_WIDTH-1:0] num_clamped;

    // byte_ready_q is only ever high in COLLECT, so it doubles as the state qualifier.
    assign xfer        = bus.byte_valid & byte_ready_q;
    assign num_clamped = (bus.load_num_words > NUM_WORDS_C) ? NUM_WORDS_C : bus.load_num_words;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.load_start) begin
                    n_d        = num_clamped;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = (num_clamped == '0) ? S_DONE : S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (xfer) begin
                    timer_d                          = '0;
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
                    byte_cnt_d                       = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        waddr_d = word_cnt_q;
                        wdata_d = {bus.byte_data, word_q[INST_WIDTH-9:0]};
                        state_d = S_WRITE;
                    end
                end else if (timer_q >= TIMEOUT_C - TIMER_W'(1)) begin
                    // Saturate at the limit; the count is only cleared by a byte or a new start.
                    timer_d = TIMEOUT_C;
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            S_WRITE: begin
                word_cnt_d = word_cnt_q + INST_ADDR_WIDTH'(1);
                byte_cnt_d = '0;
                state_d    = (word_cnt_q == n_q - INST_ADDR_WIDTH'(1)) ? S_DONE : S_COLLECT;
            end

            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        byte_ready_d = (state_d == S_COLLECT);
        write_d      = (state_d == S_WRITE);
        hold_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            timer_q      <= '0;
            word_q       <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            byte_ready_q <= 1'b0;
            write_q      <= 1'b0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            timer_q      <= timer_d;
            word_q       <= word_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            byte_ready_q <= byte_ready_d;
            write_q      <= write_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.byte_ready         = byte_ready_q;
    assign bus.dma_inst_mem_waddr = waddr_q;
    assign bus.dma_inst_mem_wdata = wdata_q;
    assign bus.inst_mem_write     = write_q;
    assign bus.cpu_hold           = hold_q;
    assign bus.load_done          = done_q;
    assign bus.load_err           = err_q;

endmodule

// File: tb/tb_inst_dma_loader.sv
// Self-checking bench for inst_dma_loader: table-driven loads, randomized loads
// against a word-level memory model, and hand-written timing/corner sequences.
module tb_inst_dma_loader;

    localparam int NUM_WORDS    = 128;
    localparam int BYTE_TIMEOUT = 1024;

    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;

    inst_dma_loader_if #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32)) bus ();

    inst_dma_loader #(
        .INST_WIDTH     (32),
        .INST_ADDR_WIDTH(32),
        .NUM_WORDS      (NUM_WORDS),
        .BYTE_TIMEOUT   (BYTE_TIMEOUT)
    ) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .bus      (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        got_q[$];
    logic [7:0] sent_q[$];

    // Table row: load request and byte stream shape, plus the expected outcome.
    typedef struct {
        logic [31:0] n;
        int          nbytes;
        int          max_gap;
        int          exp_writes;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    // Every strobe is exactly one cycle wide, so one sample per cycle captures each write once.
    always @(negedge cpu_clk) begin
        if (cpu_rst_n && bus.inst_mem_write)
            got_q.push_back({bus.dma_inst_mem_waddr, bus.dma_inst_mem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [31:0] n);
        sent_q.delete();
        got_q.delete();
        bus.load_start     = 1'b1;
        bus.load_num_words = n;
        @(negedge cpu_clk);
        bus.load_start     = 1'b0;
    endtask

    // Offers one byte after 'gap' idle cycles; returns at the negedge after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge cpu_clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int k = 0; k < 16 && !bus.byte_ready; k++) @(negedge cpu_clk);
        if (!bus.byte_ready) check("byte_accept", {31'd0, bus.byte_ready}, 32'd1);
        @(negedge cpu_clk);
        sent_q.push_back(b);
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(bus.load_done || bus.load_err); i++) @(negedge cpu_clk);
        check("end_reached", {31'd0, bus.load_done | bus.load_err}, 32'd1);
    endtask

    // Reference: word i of the load is bytes 4i..4i+3 little-endian at address i,
    // for every complete word up to the clamped request length.
    task automatic check_model(input logic [31:0] n);
        int nclamp, exp_cnt;
        nclamp  = (n > NUM_WORDS) ? NUM_WORDS : int'(n);
        exp_cnt = (sent_q.size() / 4 < nclamp) ? sent_q.size() / 4 : nclamp;
        check("write_count", got_q.size(), exp_cnt);
        for (int i = 0; i < exp_cnt && i < got_q.size(); i++) begin
            check("waddr", got_q[i].addr, i);
            check("wdata", got_q[i].data,
                  {sent_q[4*i+3], sent_q[4*i+2], sent_q[4*i+1], sent_q[4*i]});
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {27'd0, bus.byte_ready, bus.inst_mem_write, bus.cpu_hold,
                     bus.load_done, bus.load_err}, 32'd0);
    endtask

    vec_t vecs[7];
    logic [7:0] b1[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] b2[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    initial begin
        vecs[0] = '{n: 32'd2,   nbytes: 8,   max_gap: 0, exp_writes: 2,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{n: 32'd1,   nbytes: 4,   max_gap: 3, exp_writes: 1,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{n: 32'd1,   nbytes: 2,   max_gap: 0, exp_writes: 0,   exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{n: 32'd0,   nbytes: 0,   max_gap: 0, exp_writes: 0,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{n: 32'd5,   nbytes: 20,  max_gap: 2, exp_writes: 5,   exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{n: 32'd3,   nbytes: 6,   max_gap: 1, exp_writes: 1,   exp_done: 1'b0, exp_err: 1'b1};
        vecs[6] = '{n: 32'd200, nbytes: 512, max_gap: 0, exp_writes: 128, exp_done: 1'b1, exp_err: 1'b0};

        bus.load_start     = 1'b0;
        bus.load_num_words = '0;
        bus.byte_valid     = 1'b0;
        bus.byte_data      = '0;

        // Reset state.
        repeat (3) @(negedge cpu_clk);
        check_idle_outputs("reset_flags");
        check("reset_waddr", bus.dma_inst_mem_waddr, 32'd0);
        check("reset_wdata", bus.dma_inst_mem_wdata, 32'd0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        // byte_valid in IDLE is not consumed.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        repeat (3) begin
            @(negedge cpu_clk);
            check("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        bus.byte_valid = 1'b0;

        // Back-to-back two-word load with exact strobe timing.
        start_load(32'd2);
        for (int i = 0; i < 4; i++) send_byte(b1[i], 0);
        check("w0_strobe", {29'd0, bus.inst_mem_write, bus.byte_ready, bus.cpu_hold}, 32'b101);
        check("w0_waddr", bus.dma_inst_mem_waddr, 32'd0);
        check("w0_wdata", bus.dma_inst_mem_wdata, 32'h0000_0013);
        for (int i = 4; i < 8; i++) send_byte(b1[i], 0);
        check("w1_strobe", {29'd0, bus.inst_mem_write, bus.cpu_hold, bus.load_done}, 32'b110);
        @(negedge cpu_clk);
        check("w1_done", {29'd0, bus.inst_mem_write, bus.cpu_hold, bus.load_done}, 32'b001);
        check("w1_waddr_hold", bus.dma_inst_mem_waddr, 32'd1);
        check("w1_wdata_hold", bus.dma_inst_mem_wdata, 32'h0010_0093);
        check_model(32'd2);

        // byte_valid in DONE is not consumed; then a gapped single-word load.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        repeat (3) begin
            @(negedge cpu_clk);
            check("done_ready", {31'd0, bus.byte_ready}, 32'd0);
        end
        bus.byte_valid = 1'b0;
        start_load(32'd1);
        for (int i = 0; i < 4; i++) send_byte(b2[i], 3);
        check("gap_write", {30'd0, bus.inst_mem_write, bus.byte_ready}, 32'b10);
        check("gap_wdata", bus.dma_inst_mem_wdata, 32'hDDCC_BBAA);
        wait_end(10);
        check_model(32'd1);

        // Byte timeout lands exactly BYTE_TIMEOUT idle cycles after the last byte.
        start_load(32'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        repeat (BYTE_TIMEOUT - 1) @(negedge cpu_clk);
        check("to_early", {30'd0, bus.load_err, bus.cpu_hold}, 32'b01);
        @(negedge cpu_clk);
        check("to_err", {29'd0, bus.load_err, bus.cpu_hold, bus.load_done}, 32'b100);
        check("to_no_write", got_q.size(), 32'd0);
        start_load(32'd1);
        check("restart_clr_err", {30'd0, bus.load_err, bus.cpu_hold}, 32'b01);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 0);
        wait_end(10);
        check_model(32'd1);

        // Zero-length load completes the next cycle with no write.
        start_load(32'd0);
        check("n0_done", {30'd0, bus.load_done, bus.cpu_hold}, 32'b10);
        repeat (2) @(negedge cpu_clk);
        check("n0_no_write", got_q.size(), 32'd0);

        // load_start during a load is ignored.
        start_load(32'd2);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        bus.load_start     = 1'b1;
        bus.load_num_words = 32'd5;
        @(negedge cpu_clk);
        bus.load_start     = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
        wait_end(10);
        check("midstart_done", {31'd0, bus.load_done}, 32'd1);
        check_model(32'd2);

        // Asynchronous reset mid-word clears outputs immediately.
        start_load(32'd3);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        send_byte(8'hEE, 0);
        #2 cpu_rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst_flags");
        check("midrst_waddr", bus.dma_inst_mem_waddr, 32'd0);
        check("midrst_wdata", bus.dma_inst_mem_wdata, 32'd0);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        check_idle_outputs("postrst_idle");
        start_load(32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        wait_end(10);
        check_model(32'd1);

        // Table-driven loads.
        for (int v = 0; v < 7; v++) begin
            start_load(vecs[v].n);
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(8'($urandom), int'($urandom_range(0, vecs[v].max_gap)));
            wait_end(BYTE_TIMEOUT + 50);
            check("vec_done", {31'd0, bus.load_done}, {31'd0, vecs[v].exp_done});
            check("vec_err", {31'd0, bus.load_err}, {31'd0, vecs[v].exp_err});
            check("vec_hold", {31'd0, bus.cpu_hold}, 32'd0);
            check("vec_writes", got_q.size(), vecs[v].exp_writes);
            check_model(vecs[v].n);
            if (got_q.size() > 0)
                check("vec_last_addr", got_q[got_q.size()-1].addr, vecs[v].exp_writes - 1);
        end

        // Randomized complete loads.
        for (int r = 0; r < 15; r++) begin
            logic [31:0] n;
            n = $urandom_range(1, 6);
            start_load(n);
            for (int i = 0; i < 4 * int'(n); i++)
                send_byte(8'($urandom), int'($urandom_range(0, 3)));
            wait_end(20);
            check("rnd_flags", {29'd0, bus.load_done, bus.load_err, bus.cpu_hold}, 32'b100);
            check_model(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
